// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP load sequencer: sequencer states,
// default geometry of a job and a counter-width helper.
package mlp_pkg;

  localparam int DEF_WORDS_PER_ROW = 8;
  localparam int DEF_NUM_ROWS      = 16;
  localparam int DEF_NUM_WGROUPS   = 8;
  localparam int DEF_WT_WORDS      = 16;
  localparam int DEF_GAP_CYCLES    = 4;
  localparam int DEF_NUM_RESULTS   = 256;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_IN = 3'd1,
    LOAD_WT = 3'd2,
    GAP     = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mlp_nested_counter.sv
// Inner/outer position counter with a terminal flag. It saturates at the
// last position instead of wrapping; the owner clears it between uses.
module mlp_nested_counter
  import mlp_pkg::*;
#(
  parameter int INNER_N = 8,
  parameter int OUTER_N = 16,
  localparam int IW = cnt_width(INNER_N),
  localparam int OW = cnt_width(OUTER_N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  output logic [IW-1:0] inner,
  output logic [OW-1:0] outer,
  output logic          last
);

  assign last = (inner == IW'(INNER_N - 1)) && (outer == OW'(OUTER_N - 1));

  // Step the inner position, carrying into the outer one; hold at the end.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      inner <= '0;
      outer <= '0;
    end else if (inc && !last) begin
      if (inner == IW'(INNER_N - 1)) begin
        inner <= '0;
        outer <= outer + OW'(1);
      end else begin
        inner <= inner + IW'(1);
      end
    end
  end

endmodule

// File: rtl/mlp_load_sequencer.sv
// Streams host words into the accelerator as one input load followed by
// per-layer weight loads, then collects the result beats of the job.
module mlp_load_sequencer
  import mlp_pkg::*;
#(
  parameter int WORDS_PER_ROW = DEF_WORDS_PER_ROW,
  parameter int NUM_ROWS      = DEF_NUM_ROWS,
  parameter int NUM_WGROUPS   = DEF_NUM_WGROUPS,
  parameter int WT_WORDS      = DEF_WT_WORDS,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int NUM_RESULTS   = DEF_NUM_RESULTS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [2:0]  cfg_layers_i,
  input  logic        s_valid_i,
  input  logic [31:0] s_data_i,
  output logic        s_ready_o,
  output logic        load_en_o,
  output logic [31:0] load_payload_o,
  output logic        load_type_o,
  output logic [3:0]  input_load_number_o,
  output logic [2:0]  layer_number_o,
  output logic [2:0]  weight_number_o,
  input  logic        result_valid_i,
  input  logic [31:0] result_payload_i,
  output logic        result_valid_o,
  output logic [31:0] result_payload_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int GW    = cnt_width(GAP_CYCLES);
  localparam int IN_IW = cnt_width(WORDS_PER_ROW);
  localparam int IN_OW = cnt_width(NUM_ROWS);
  localparam int WT_IW = cnt_width(WT_WORDS);
  localparam int WT_OW = cnt_width(NUM_WGROUPS);
  localparam int RS_IW = cnt_width(NUM_RESULTS);

  state_t state, state_next;

  logic [2:0]       cfg_layers;
  logic [2:0]       layer;
  logic [GW-1:0]    gap_cnt;
  logic             gap_last;
  logic             xfer;
  logic             start_ok;
  logic             err_set;
  logic             in_inc, in_last;
  logic             wt_inc, wt_last;
  logic             res_inc, res_last;
  logic [IN_IW-1:0] in_word;
  logic [IN_OW-1:0] in_row;
  logic [WT_IW-1:0] wt_word;
  logic [WT_OW-1:0] wt_group;
  logic [RS_IW-1:0] res_count;
  logic             res_outer;
  logic             unused_cnt_bits;

  assign s_ready_o = (state == LOAD_IN) || (state == LOAD_WT);
  assign busy_o    = (state != IDLE);
  assign done_o    = (state == DONE);

  // An abort in the same cycle as a handshake drops the word.
  assign xfer     = s_ready_o & s_valid_i & ~abort_i;
  assign in_inc   = xfer & (state == LOAD_IN);
  assign wt_inc   = xfer & (state == LOAD_WT);
  assign res_inc  = (state == DRAIN) & result_valid_i;
  assign gap_last = (gap_cnt == GW'(GAP_CYCLES - 1));
  assign start_ok = (state == IDLE) & start_i;
  assign err_set  = (result_valid_i & (state != DRAIN) & (state != DONE))
                  | (start_i & busy_o);

  // Word and result positions only matter through the terminal flags.
  assign unused_cnt_bits = ^{in_word, res_count, res_outer};

  mlp_nested_counter #(.INNER_N(WORDS_PER_ROW), .OUTER_N(NUM_ROWS)) u_in_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (state != LOAD_IN),
    .inc   (in_inc),
    .inner (in_word),
    .outer (in_row),
    .last  (in_last)
  );

  mlp_nested_counter #(.INNER_N(WT_WORDS), .OUTER_N(NUM_WGROUPS)) u_wt_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (state != LOAD_WT),
    .inc   (wt_inc),
    .inner (wt_word),
    .outer (wt_group),
    .last  (wt_last)
  );

  mlp_nested_counter #(.INNER_N(NUM_RESULTS), .OUTER_N(1)) u_res_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (state != DRAIN),
    .inc   (res_inc),
    .inner (res_count),
    .outer (res_outer),
    .last  (res_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state selection; abort overrides every other transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = LOAD_IN;
      LOAD_IN: if (in_inc && in_last) state_next = LOAD_WT;
      LOAD_WT: if (wt_inc && wt_last) state_next = GAP;
      GAP:     if (gap_last) state_next = (layer == cfg_layers) ? DRAIN : LOAD_WT;
      DRAIN:   if (res_inc && res_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_i && (state != IDLE)) state_next = IDLE;
  end

  // Job bookkeeping: latched layer count, layer index, gap timer, sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_layers <= '0;
      layer      <= '0;
      gap_cnt    <= '0;
      err_o      <= 1'b0;
    end else begin
      if (start_ok) begin
        cfg_layers <= cfg_layers_i;
        layer      <= '0;
      end else if ((state == GAP) && (state_next == LOAD_WT)) begin
        layer <= layer + 3'd1;
      end
      gap_cnt <= ((state == GAP) && !gap_last) ? gap_cnt + GW'(1) : '0;
      if (start_ok)     err_o <= 1'b0;
      else if (err_set) err_o <= 1'b1;
    end
  end

  // Accelerator load port: one pulse per accepted word, fields held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_en_o           <= 1'b0;
      load_payload_o      <= '0;
      load_type_o         <= 1'b0;
      input_load_number_o <= '0;
      weight_number_o     <= '0;
    end else begin
      load_en_o <= xfer;
      if (xfer) begin
        load_payload_o  <= s_data_i;
        load_type_o     <= (state == LOAD_IN);
        weight_number_o <= 3'(wt_group);
        if (state == LOAD_IN) input_load_number_o <= 4'(in_row);
        else                  input_load_number_o <= 4'(wt_word);
      end
    end
  end

  // Result pass-through with one register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_valid_o   <= 1'b0;
      result_payload_o <= '0;
    end else begin
      result_valid_o   <= result_valid_i;
      result_payload_o <= result_payload_i;
    end
  end

  assign layer_number_o = layer;

endmodule

// File: doc/mlp_load_sequencer.md
MLP_LOAD_SEQUENCER -- requirements
Module: mlp_load_sequencer

Interface
REQ-001 SHALL have parameters: WORDS_PER_ROW=8, words per 256-bit input row; NUM_ROWS=16, input rows per layer-0 load; NUM_WGROUPS=8, weight groups per layer; WT_WORDS=16, words per weight group; GAP_CYCLES=4, idle cycles between layers; NUM_RESULTS=256, result words expected.
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  begin a job; sampled in IDLE only
- abort_i  in  1  cancel the current job
- cfg_layers_i  in  3  number of layers minus 1 (0..7); latched on start
- s_valid_i  in  1  host word valid
- s_data_i  in  32  host word
- s_ready_o  out  1  sequencer accepts word
- load_en_o  out  1  to accelerator load_en_i
- load_payload_o  out  32  to accelerator load_payload_i
- load_type_o  out  1  1=input, 0=weight
- input_load_number_o  out  4  row index
- layer_number_o  out  3  current layer
- weight_number_o  out  3  weight group
- result_valid_i  in  1  from accelerator
- result_payload_i  in  32  from accelerator
- result_valid_o  out  1  registered result
- result_payload_o  out  32  registered result data
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky protocol error

Function
REQ-003 SHALL implement states IDLE, LOAD_IN, LOAD_WT, GAP, DRAIN, DONE.
REQ-004 IDLE -> LOAD_IN on start_i=1; latch cfg_layers_i; clear layer, row, group, word and result counters; clear err_o.
REQ-005 s_ready_o SHALL be 1 exactly in LOAD_IN and LOAD_WT; a word transfers when s_valid_i & s_ready_o.
REQ-006 On each transfer, next cycle: load_en_o=1, load_payload_o=s_data_i, load_type_o=1 (LOAD_IN) or 0 (LOAD_WT), index outputs = counter values at transfer; otherwise load_en_o=0, other load outputs hold.
REQ-007 LOAD_IN: word counter 0..WORDS_PER_ROW-1 nested in row 0..NUM_ROWS-1; input_load_number_o=row; after 128th transfer -> LOAD_WT.
REQ-008 LOAD_WT: word counter 0..WT_WORDS-1 nested in group 0..NUM_WGROUPS-1; weight_number_o=group; input_load_number_o=word[3:0]; after 128th transfer -> GAP.
REQ-009 GAP: hold GAP_CYCLES cycles; then if layer==cfg -> DRAIN, else layer+1 and -> LOAD_WT; LOAD_IN occurs for layer 0 only.
REQ-010 s_valid_i=0 SHALL stall: counters hold, no load_en_o pulse, no state change.
REQ-011 result_valid_o/result_payload_o SHALL register result_valid_i/result_payload_i with 1-cycle latency in all states.
REQ-012 DRAIN: count result_valid_i beats; on NUM_RESULTS-th beat -> DONE.
REQ-013 DONE: done_o=1 for one cycle, then -> IDLE.
REQ-014 busy_o=1 in every state except IDLE.
REQ-015 err_o SHALL set, and hold until the next accepted start, on result_valid_i outside DRAIN or DONE, or on start_i=1 while busy_o=1; start while busy SHALL otherwise be ignored.
REQ-016 abort_i in any non-IDLE state -> IDLE next cycle; s_ready_o=0 and load_en_o=0 from that cycle; no done_o; abort has priority over every transition.
REQ-017 Counters SHALL never wrap past their limits; the terminal transfer and the state change occur on the same edge.

Reset
REQ-018 rst=1 at a clk edge SHALL force IDLE, every output 0, all counters 0, err_o 0, mid-operation included; latched config SHALL be 0.

Structure
REQ-019 State enum and the REQ-001 defaults SHALL reside in shared package mlp_pkg.
REQ-020 One sub-module SHALL exist: mlp_nested_counter (inner/outer counter with terminal flag), instantiated for LOAD_IN, LOAD_WT and DRAIN.

Verification
REQ-021 cfg=0, 256 contiguous words, 256 results -> 128 type=1 beats (row 15 on beats 121-128), 128 type=0 beats, 4 GAP cycles, done_o pulse, err_o=0.
REQ-022 cfg=2, no stalls -> layer_number_o 0,1,2; LOAD_IN once; 128+3x128 load beats; done_o after 256th result.
REQ-023 s_valid_i toggled 1-0 during LOAD_WT -> load_en_o mirrors transfers one cycle later, indices unchanged across the gaps.
REQ-024 result_valid_i during LOAD_IN -> err_o=1 and held; start_i during LOAD_WT -> ignored, err_o=1.
REQ-025 abort_i at word 50, then start -> IDLE next cycle, no done_o; restart begins at row 0, word 0, layer 0.
REQ-026 rst asserted in GAP -> all outputs 0 next cycle; a fresh job completes normally.
